// File: rtl/stall_mem_ctrl.sv
// stall_mem_ctrl: multi-cycle 16-bit data memory; holds the requester with 'stall' and pulses 'done'.
// Optional MEM_RAND_STALL_EN adds 0..3 LFSR-driven extra wait cycles per request.
module stall_mem_ctrl #(
    parameter int MEM_AW  = 8,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("stall_mem_ctrl: LATENCY must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt, load_cnt;
    logic              lat_wr;
    logic [15:0]       lat_addr, lat_data;
    logic              complete, acc_wr;
    logic [15:0]       acc_addr, acc_data;
    logic [MEM_AW-1:0] acc_idx;
    logic [15:0]       mem [2**MEM_AW];

`ifdef MEM_RAND_STALL_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 4'b1001;
        else     lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign load_cnt = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
    assign load_cnt = 5'(LATENCY - 1);
`endif

    // Upper address bits fall away in the shift/truncate, so addresses alias.
    assign acc_idx = MEM_AW'(acc_addr >> 1);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        complete  = 1'b0;
        acc_wr    = lat_wr;
        acc_addr  = lat_addr;
        acc_data  = lat_data;
        case (state)
            IDLE: begin
                // A zero wait count completes on the accepting edge itself.
                acc_wr   = wr;
                acc_addr = addr;
                acc_data = data_in;
                if (enable) begin
                    stall = 1'b1;
                    if (load_cnt == 5'd0) begin
                        state_nxt = DONE;
                        complete  = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 5'd1) begin
                    state_nxt = DONE;
                    complete  = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            lat_wr   <= 1'b0;
            lat_addr <= 16'd0;
            lat_data <= 16'd0;
            data_out <= 16'd0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && enable) begin
                cnt      <= load_cnt;
                lat_wr   <= wr;
                lat_addr <= addr;
                lat_data <= data_in;
            end else if (state == BUSY) begin
                cnt <= cnt - 5'd1;
            end
            if (complete) begin
                err <= acc_addr[0];
                if (!acc_addr[0] && !acc_wr) data_out <= mem[acc_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (complete && acc_wr && !acc_addr[0]) mem[acc_idx] <= acc_data;
    end

endmodule

// File: tb/tb_stall_mem_ctrl.sv
// Bench for stall_mem_ctrl: directed scenarios plus random load/store traffic against a word-array model.
module tb_stall_mem_ctrl;
    localparam int MEM_AW  = 8;
    localparam int LATENCY = 4;
    localparam int WORDS   = 2**MEM_AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_mem [WORDS];
    logic [15:0] exp_do  = 16'd0;
    logic        exp_err = 1'b0;
    logic [3:0]  lfsr_m;

    always #5 clk = ~clk;

    stall_mem_ctrl #(.MEM_AW(MEM_AW), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .stall    (stall),
        .done     (done),
        .err      (err)
    );

    // Reference sequence for the optional random extra wait (x^4+x^3+1, seed 1001).
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 4'b1001;
        else     lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    end

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % WORDS;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d);
        int lat;
        int exp_lat;
        @(negedge clk);
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        exp_lat = LATENCY;
`ifdef MEM_RAND_STALL_EN
        exp_lat = LATENCY + int'(lfsr_m[1:0]);
`endif
        #1 check("stall_on_request", stall, 1);
        @(posedge clk);
        @(negedge clk);
        enable  = 1'b0;
        wr      = 1'($urandom);
        addr    = 16'($urandom);
        data_in = 16'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            check("stall_while_busy", stall, 1);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        if (a[0]) begin
            exp_err = 1'b1;
        end else begin
            exp_err = 1'b0;
            if (w) model_mem[widx(a)] = d;
            else   exp_do = model_mem[widx(a)];
        end
        check("done_pulse", done, 1);
        check("err", err, exp_err);
        check("data_out", data_out, exp_do);
        check("stall_in_done", stall, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [15:0] pool [8];
        logic [15:0] a;

        rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = 16'd0; data_in = 16'd0;
        #1;
        check("reset_data_out", data_out, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_stall", stall, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Store then load the same word.
        req(1'b1, 16'h0010, 16'hBEEF);
        req(1'b0, 16'h0010, 16'h0000);
        check("store_load_beef", data_out, 16'hBEEF);

        // Misaligned load and store leave data and array untouched.
        req(1'b0, 16'h0011, 16'h0000);
        check("misaligned_err", err, 1);
        req(1'b1, 16'h0011, 16'hDEAD);
        req(1'b0, 16'h0010, 16'h0000);
        check("misaligned_no_write", data_out, 16'hBEEF);

        // Enable held high across three back-to-back loads.
        @(negedge clk);
        enable = 1'b1; wr = 1'b0; addr = 16'h0010; data_in = 16'h0000;
        #1 check("held_stall_first", stall, 1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("held_stall_vs_done", stall, !done);
            if (done) pulses++;
        end
        enable = 1'b0;
`ifndef MEM_RAND_STALL_EN
        check("held_done_count", pulses, 3);
`endif
        exp_do = model_mem[widx(16'h0010)];
        exp_err = 1'b0;
        check("held_data_out", data_out, exp_do);
        @(negedge clk);
        while (done || stall) @(negedge clk);

        // Reset two cycles into a store discards it.
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_data_out", data_out, 0);
        check("midreset_done", done, 0);
        check("midreset_err", err, 0);
        check("midreset_stall", stall, 0);
        exp_do = 16'd0; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req(1'b0, 16'h0010, 16'h0000);
        check("reset_discard_store", data_out, 16'hBEEF);

        // Address aliasing above the word-index bits.
        req(1'b1, 16'h0002, 16'hAAAA);
        req(1'b1, 16'(16'h0002 + 2**(MEM_AW+1)), 16'h5555);
        req(1'b0, 16'h0002, 16'h0000);
        check("alias_overwrite", data_out, 16'h5555);

        // Random traffic over a pool of pre-written words with aliased addresses.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'(((i * 16 + 3) * 2) + ($urandom_range(0, 127) * 512));
            req(1'b1, pool[i], 16'($urandom));
        end
        for (int k = 0; k < 30; k++) begin
            a = pool[$urandom_range(0, 7)] ^ 16'($urandom_range(0, 127) * 512);
            if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
            req(1'($urandom), a, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
